// File: rtl/sync_fifo_af_pkg.sv
// sync_fifo_af_pkg: default sizing shared by the FIFO and its storage.
// Instances normally override these through parameters; the package only
// holds the defaults so every consumer of the FIFO starts from one place.
package sync_fifo_af_pkg;

    localparam int FIFO_DEF_WIDTH        = 32;
    localparam int FIFO_DEF_DEPTH        = 16;
    localparam int FIFO_DEF_ALMOST_FULL  = 8;
    localparam int FIFO_DEF_ALMOST_EMPTY = 2;

endpackage

// File: rtl/sync_fifo_af_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// Read-first: a read and a write to the same address in the same cycle
// return the old contents. The read register clears on rst so the output is
// never X after reset; the array itself is not reset (block-RAM friendly).
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we/wa/wd : write enable, address, data
//   re/ra    : read enable, address
//   rd       : registered read data, holds when re=0
import sync_fifo_af_pkg::*;

module sdp_ram #(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [WIDTH-1:0]         rd
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // Separate process: reset only touches the output register.
    always_ff @(posedge clk) begin
        if (rst)
            rd <= '0;
        else if (re)
            rd <= mem[ra];
    end

endmodule

// File: rtl/sync_fifo_af.sv
// sync_fifo_af: single-clock FIFO with a one-cycle registered read port.
// A pop in cycle N presents the head on q in cycle N+1. All flags decode the
// registered count, so they move the cycle after the push/pop that changed it.
//   rst, clk     : synchronous active-high reset, clock
//   push, d      : write request and data (dropped when full unless popping)
//   pop, q       : read request (ignored when empty), registered read data
//   full, empty  : count == DEPTH, count == 0
//   count        : stored entries
//   almost_empty : count <= ALMOST_EMPTY_COUNT
//   almost_full  : count >= DEPTH - ALMOST_FULL_COUNT
import sync_fifo_af_pkg::*;

module sync_fifo_af #(
    parameter int WIDTH              = FIFO_DEF_WIDTH,
    parameter int DEPTH              = FIFO_DEF_DEPTH,
    parameter int ALMOST_FULL_COUNT  = FIFO_DEF_ALMOST_FULL,
    parameter int ALMOST_EMPTY_COUNT = FIFO_DEF_ALMOST_EMPTY
) (
    input  logic                       rst,
    input  logic                       clk,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_empty,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    // Thresholds clamped into [0, DEPTH] so they fit the count width; an
    // almost-full threshold of 0 makes almost_full permanently asserted.
    localparam int AF_TH = (DEPTH > ALMOST_FULL_COUNT) ? DEPTH - ALMOST_FULL_COUNT : 0;
    localparam int AE_TH = (ALMOST_EMPTY_COUNT < DEPTH) ? ALMOST_EMPTY_COUNT : DEPTH;

    logic [AW-1:0] wp, rp;
    logic          push_ok, pop_ok;

    // A pop frees a slot this cycle, so a full FIFO can still take a push;
    // the RAM is read-first, so the old head is read before it is replaced.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wp <= wp + AW'(1);
            if (pop_ok)
                rp <= rp + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_TH));
    assign almost_empty = (count <= CW'(AE_TH));

    // Writes are suppressed during reset so nothing lands in the array while
    // the pointers are being cleared.
    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (push_ok && !rst),
        .wa  (wp),
        .wd  (d),
        .re  (pop_ok && !rst),
        .ra  (rp),
        .rd  (q)
    );

endmodule

// File: tb/tb_sync_fifo_af.sv
module tb_sync_fifo_af;

    localparam int W  = 64;
    localparam int DP = 32;
    localparam int AF = 8;
    localparam int AE = 2;

    logic          rst, clk, push, pop;
    logic [W-1:0]  d, q;
    logic          full, empty, almost_empty, almost_full;
    logic [5:0]    count;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] model [$];
    logic [W-1:0] exp_q;

    sync_fifo_af #(
        .WIDTH(W), .DEPTH(DP), .ALMOST_FULL_COUNT(AF), .ALMOST_EMPTY_COUNT(AE)
    ) dut (
        .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q),
        .full(full), .empty(empty), .count(count),
        .almost_empty(almost_empty), .almost_full(almost_full)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle of traffic; the bench's queue decides acceptance on its own.
    task automatic do_op(input logic p, input logic o, input logic [W-1:0] v);
        logic po, pu;
        po   = o && (model.size() != 0);
        pu   = p && (model.size() < DP || po);
        push = p; pop = o; d = v;
        @(posedge clk); #1;
        push = 0; pop = 0;
        if (po) exp_q = model.pop_front();
        if (pu) model.push_back(v);
        chk("count", W'(count), W'(model.size()));
        chk("q", q, exp_q);
        chk("empty", W'(empty), W'(model.size() == 0));
        chk("full", W'(full), W'(model.size() == DP));
        chk("aempty", W'(almost_empty), W'(model.size() <= AE));
        chk("afull", W'(almost_full), W'(model.size() >= DP - AF));
    endtask

    task automatic do_reset(input logic p, input logic o);
        rst = 1; push = p; pop = o; d = 64'hBAD0_BAD0;
        @(posedge clk); #1;
        rst = 0; push = 0; pop = 0;
        model.delete();
        exp_q = '0;
    endtask

    initial begin
        rst = 1; push = 0; pop = 0; d = '0; exp_q = '0;
        @(posedge clk); #1;
        do_reset(0, 0);

        // Reset state, hand values
        chk("rst_empty", W'(empty), 1);
        chk("rst_full", W'(full), 0);
        chk("rst_count", W'(count), 0);
        chk("rst_aempty", W'(almost_empty), 1);
        chk("rst_afull", W'(almost_full), 0);
        chk("rst_q", q, 0);

        // Three pushes, three pops
        do_op(1, 0, 64'hA); chk("cnt1", W'(count), 1);
        do_op(1, 0, 64'hB); chk("cnt2", W'(count), 2);
        do_op(1, 0, 64'hC); chk("cnt3", W'(count), 3);
        do_op(0, 1, 0); chk("q_a", q, 64'hA); chk("cnt2b", W'(count), 2);
        do_op(0, 1, 0); chk("q_b", q, 64'hB); chk("cnt1b", W'(count), 1);
        do_op(0, 1, 0); chk("q_c", q, 64'hC); chk("empty_end", W'(empty), 1);

        // No bypass: pop together with first push into empty is ignored
        do_op(1, 1, 64'h55); chk("nobyp_cnt", W'(count), 1); chk("nobyp_q", q, 64'hC);
        do_op(0, 1, 0); chk("nobyp_pop", q, 64'h55);

        // almost_full at 24 entries
        for (int i = 1; i <= 24; i++) begin
            do_op(1, 0, W'(64'h100 + i));
            if (i == 23) chk("af_23", W'(almost_full), 0);
        end
        chk("af_24", W'(almost_full), 1);
        do_op(0, 1, 0); chk("af_pop", W'(almost_full), 0); chk("af_pop_q", q, 64'h101);

        // Fill to 32, dropped push, drain
        for (int i = 25; i <= 33; i++) do_op(1, 0, W'(64'h100 + i));
        chk("full32", W'(full), 1); chk("cnt32", W'(count), 32);
        do_op(1, 0, 64'hDEAD); chk("drop_cnt", W'(count), 32);
        for (int i = 0; i < 32; i++) begin
            do_op(0, 1, 0);
            chk("drain_ord", q, W'(64'h102 + i));
        end
        chk("drain_empty", W'(empty), 1);

        // Full with simultaneous push+pop
        for (int i = 0; i < 32; i++) do_op(1, 0, W'(64'h200 + i));
        do_op(1, 1, 64'hBEEF);
        chk("pp_cnt", W'(count), 32); chk("pp_q", q, 64'h200);
        for (int i = 0; i < 32; i++) do_op(0, 1, 0);
        chk("pp_last", q, 64'hBEEF);
        do_op(0, 1, 0); chk("pop_empty_q", q, 64'hBEEF); chk("pop_empty_cnt", W'(count), 0);

        // Random traffic through wrap-around
        for (int i = 0; i < 100; i++)
            do_op(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                  {$urandom, $urandom});

        // Mid-stream reset with content present and traffic requested
        for (int i = 0; i < 5; i++) do_op(1, 0, W'(64'h300 + i));
        do_reset(1, 1);
        chk("mrst_cnt", W'(count), 0); chk("mrst_empty", W'(empty), 1); chk("mrst_q", q, 0);
        do_op(0, 1, 0); chk("mrst_pop_q", q, 0);
        do_op(1, 0, 64'h777);
        do_op(0, 1, 0); chk("mrst_fresh", q, 64'h777);
        do_op(0, 1, 0); chk("mrst_hold", q, 64'h777);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
